store_splitter: RTL

STORE_SPLITTER -- requirements
Module: store_splitter

---
 rtl/store_splitter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/store_splitter.sv
// store_splitter: turns one store request (address, right-justified data, size)
// into one or two aligned bus beats with byte strobes. A store that crosses a
// DATA_W/8-byte boundary is split into two beats, or rejected when misaligned
// stores are not allowed.
//
// Ports
//   clk        clock, rising edge
//   resetn     asynchronous active-low reset
//   req_valid  store request present
//   req_ready  request accepted this cycle (only when idle)
//   req_addr   byte address of the store
//   req_data   store data, byte 0 in bits 7:0
//   req_msize  access size: 0 = 1 byte, 1 = 2, 2 = 4, 3 = 8
//   bus_valid  beat present on the bus
//   bus_ready  bus accepts the beat
//   bus_addr   beat address, aligned to DATA_W/8
//   bus_data   lane-positioned write data, zero in disabled lanes
//   bus_strobe byte enables, bit i = byte lane i
//   done       one-cycle pulse after the last beat is accepted
//   err        one-cycle pulse after a rejected request is accepted
module store_splitter #(
    parameter int unsigned DATA_W         = 64,
    parameter int unsigned ADDR_W         = 64,
    parameter int unsigned ALLOW_MISALIGN = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_data,
    input  logic [1:0]            req_msize,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_data,
    output logic [DATA_W/8-1:0]   bus_strobe,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(BYTES);
    localparam int          NLANES = 2 * BYTES;

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

    state_e              state_q, state_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [1:0]          msize_q;

    logic                accept;
    logic [3:0]          req_n;
    logic                req_illegal;

    logic [OFF_W-1:0]    off;
    logic [3:0]          n;
    logic [NLANES-1:0]   mask_base;
    logic [NLANES-1:0]   mask;
    logic [2*DATA_W-1:0] shifted;
    logic [2*DATA_W-1:0] lane_data;
    logic                split;
    logic [ADDR_W-1:0]   beat_base;

    function automatic logic [3:0] size_bytes(input logic [1:0] m);
        return 4'd1 << m;
    endfunction

    // Request-side legality, evaluated on the live inputs at acceptance.
    assign req_n       = size_bytes(req_msize);
    assign accept      = req_valid && req_ready;
    assign req_illegal = (int'(req_n) > int'(BYTES)) ||
                         ((ALLOW_MISALIGN == 0) && ((req_addr[3:0] & (req_n - 4'd1)) != 4'd0));

    // Lane positioning from the captured request; two beats' worth of lanes.
    assign off       = addr_q[OFF_W-1:0];
    assign n         = size_bytes(msize_q);
    assign mask      = mask_base << off;
    assign shifted   = {{DATA_W{1'b0}}, data_q} << {off, 3'b000};
    assign split     = (int'(off) + int'(n)) > int'(BYTES);
    assign beat_base = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    always_comb begin
        mask_base = '0;
        for (int i = 0; i < NLANES; i++) begin
            mask_base[i] = (i < int'(n));
        end
    end

    // Bytes above the access size are forced to zero rather than leaking.
    always_comb begin
        lane_data = '0;
        for (int i = 0; i < NLANES; i++) begin
            lane_data[8*i +: 8] = mask[i] ? shifted[8*i +: 8] : 8'h00;
        end
    end

    // State register and completion pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Request capture; req_* is not looked at again until back in idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            data_q  <= '0;
            msize_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr;
            data_q  <= req_data;
            msize_q <= req_msize;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (req_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = StBeat0;
                    end
                end
            end
            StBeat0: begin
                if (bus_ready) begin
                    if (split) begin
                        state_d = StBeat1;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            StBeat1: begin
                if (bus_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: all bus signals are zero outside the beat states. Since they
    // derive only from registers, they hold steady while the bus stalls.
    always_comb begin
        bus_valid  = 1'b0;
        bus_addr   = '0;
        bus_data   = '0;
        bus_strobe = '0;
        unique case (state_q)
            StBeat0: begin
                bus_valid  = 1'b1;
                bus_addr   = beat_base;
                bus_data   = lane_data[DATA_W-1:0];
                bus_strobe = mask[BYTES-1:0];
            end
            StBeat1: begin
                bus_valid  = 1'b1;
                bus_addr   = beat_base + ADDR_W'(BYTES);
                bus_data   = lane_data[2*DATA_W-1:DATA_W];
                bus_strobe = mask[NLANES-1:BYTES];
            end
            default: ;
        endcase
        // Ready is gated by reset directly so it drops the moment reset asserts.
        req_ready = resetn && (state_q == StIdle);
        done      = done_q;
        err       = err_q;
    end

endmodule
